// File: rtl/addsub_seq_ctrl_pkg.sv
// rtl/addsub_seq_ctrl_pkg.sv - shared types, constants and slice helper for the add/sub sequencer
package addsub_seq_ctrl_pkg;

  // Width of the shared add/subtract slice.
  localparam int NIBBLE_W = 4;

  // Sequencer states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // 2-bit ripple adder built from propagate/generate terms.
  // Returns {carry_out, sum[1:0]}.
  function automatic logic [2:0] add2(input logic [1:0] x, input logic [1:0] y, input logic c);
    logic [1:0] p;
    logic [1:0] g;
    logic       c1;
    p  = x ^ y;
    g  = x & y;
    c1 = g[0] | (p[0] & c);
    return {g[1] | (p[1] & c1), p[1] ^ c1, p[0] ^ c};
  endfunction

endpackage

// File: rtl/addsub_seq_ctrl_if.sv
// rtl/addsub_seq_ctrl_if.sv - operation request/result bundle for the add/sub sequencer
interface addsub_seq_ctrl_if #(
  parameter int NIBBLES = 4
);

  localparam int W = 4 * NIBBLES;

  logic         start;
  logic         k;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  // Requester side: issues operations and observes results.
  modport master (
    output start, k, a, b,
    input  busy, done, sum, cout, ovf
  );

  // Sequencer side.
  modport slave (
    input  start, k, a, b,
    output busy, done, sum, cout, ovf
  );

endinterface

// File: rtl/addsub_seq_ctrl_add4_slice.sv
// rtl/addsub_seq_ctrl_add4_slice.sv - combinational 4-bit add slice from two chained 2-bit adders
module add4_slice
  import addsub_seq_ctrl_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                cin,
  output logic [NIBBLE_W-1:0] sum,
  output logic                cout
);

  logic [2:0] lo;
  logic [2:0] hi;

  // Low pair feeds its carry into the high pair.
  always_comb begin
    lo   = add2(a[1:0], b[1:0], cin);
    hi   = add2(a[3:2], b[3:2], lo[2]);
    sum  = {hi[1:0], lo[1:0]};
    cout = hi[2];
  end

endmodule

// File: rtl/addsub_seq_ctrl.sv
// rtl/addsub_seq_ctrl.sv - nibble-serial wide add/subtract sequencer driving an external 4-bit slice
module addsub_seq_ctrl
  import addsub_seq_ctrl_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                clk,
  input  logic                rst,
  addsub_seq_ctrl_if.slave    bus,
  output logic [NIBBLE_W-1:0] slice_a,
  output logic [NIBBLE_W-1:0] slice_b,
  output logic                slice_cin,
  input  logic [NIBBLE_W-1:0] slice_sum,
  input  logic                slice_cout
);

  localparam int W     = NIBBLE_W * NIBBLES;
  localparam int IDX_W = $clog2(NIBBLES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  state_t           state_q;
  state_t           state_d;
  logic             accept;
  logic             last;

  logic [W-1:0]     a_reg;
  logic [W-1:0]     b_reg;
  logic             k_reg;
  logic [IDX_W-1:0] idx;
  logic             carry;
  logic [W-1:0]     sum_reg;
  logic             cout_reg;
  logic             ovf_reg;
  logic             beff_msb;

  assign last     = (idx == LAST_IDX);
  assign beff_msb = b_reg[W-1] ^ k_reg;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state; a start is only taken in IDLE or DONE, never mid-run.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          accept  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (last) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.start) begin
          accept  = 1'b1;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Operand latch, nibble index, carry chain and result capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg    <= '0;
      b_reg    <= '0;
      k_reg    <= 1'b0;
      idx      <= '0;
      carry    <= 1'b0;
      sum_reg  <= '0;
      cout_reg <= 1'b0;
      ovf_reg  <= 1'b0;
    end else if (accept) begin
      a_reg    <= bus.a;
      b_reg    <= bus.b;
      k_reg    <= bus.k;
      idx      <= '0;
      // Subtract is a + ~b + 1, so the chain starts with carry = k.
      carry    <= bus.k;
      cout_reg <= 1'b0;
      ovf_reg  <= 1'b0;
    end else if (state_q == RUN) begin
      for (int n = 0; n < NIBBLES; n++) begin
        if (idx == IDX_W'(n)) begin
          sum_reg[n*NIBBLE_W +: NIBBLE_W] <= slice_sum;
        end
      end
      carry <= slice_cout;
      if (!last) begin
        idx <= idx + 1'b1;
      end else begin
        // Flags are taken straight from the final slice result so they are
        // already valid in the done cycle; the top sum bit is slice_sum[3].
        cout_reg <= slice_cout;
        ovf_reg  <= (a_reg[W-1] == beff_msb) && (slice_sum[NIBBLE_W-1] != a_reg[W-1]);
      end
    end
  end

  // Slice operand select; held at zero outside RUN.
  always_comb begin
    slice_a   = '0;
    slice_b   = '0;
    slice_cin = 1'b0;
    if (state_q == RUN) begin
      for (int n = 0; n < NIBBLES; n++) begin
        if (idx == IDX_W'(n)) begin
          slice_a = a_reg[n*NIBBLE_W +: NIBBLE_W];
          slice_b = b_reg[n*NIBBLE_W +: NIBBLE_W] ^ {NIBBLE_W{k_reg}};
        end
      end
      slice_cin = carry;
    end
  end

  assign bus.busy = (state_q == RUN);
  assign bus.done = (state_q == DONE);
  assign bus.sum  = sum_reg;
  assign bus.cout = cout_reg;
  assign bus.ovf  = ovf_reg;

endmodule
